// File: rtl/lms_pkg.sv
// Shared definitions for the LMS Wishbone master.
// Holds the sample width, the register byte addresses of the LMS core
// on the bus, the sequencer state enum and a helper that says which
// states drive a bus transaction.
package lms_pkg;

    localparam int SAMPLE_W = 16;
    localparam int ADR_W    = 32;

    localparam logic [ADR_W-1:0] ADR_X    = 32'h0000_0000;
    localparam logic [ADR_W-1:0] ADR_D    = 32'h0000_0004;
    localparam logic [ADR_W-1:0] ADR_MODE = 32'h0000_0008;
    localparam logic [ADR_W-1:0] ADR_Y    = 32'h0000_000C;
    localparam logic [ADR_W-1:0] ADR_ERR  = 32'h0000_0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_X,
        ST_WR_D,
        ST_SETTLE,
        ST_RD_Y,
        ST_RD_E,
        ST_OUT
    } lms_state_t;

    // States that own one Wishbone transaction each.
    function automatic logic is_bus_state(input lms_state_t s);
        return (s == ST_WR_MODE) || (s == ST_WR_X) || (s == ST_WR_D) ||
               (s == ST_RD_Y) || (s == ST_RD_E);
    endfunction

endpackage

// File: rtl/lms_wb_master_if.sv
// Wishbone classic bus between the LMS master and the LMS core registers.
//   wb_cyc_o / wb_stb_o / wb_we_o : master strobes
//   wb_adr_o                      : byte address (32 bit)
//   wb_dat_o                      : write data (16 bit)
//   wb_dat_i                      : read data (16 bit)
//   wb_ack_i                      : slave acknowledge
// Modports: master (drives strobes/address/write data), slave (drives ack/read data).
interface lms_wb_master_if;
    import lms_pkg::*;

    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [ADR_W-1:0]    wb_adr_o;
    logic [SAMPLE_W-1:0] wb_dat_o;
    logic [SAMPLE_W-1:0] wb_dat_i;
    logic                wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word.
//   Clk, Rst     : clock, synchronous active-high reset (empties the FIFO)
//   push/wr_data : write request and data; ignored while full
//   pop          : drop the head word; ignored while empty
//   rd_data      : current head word, valid while !empty
//   full/empty   : status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

endmodule

// File: rtl/lms_wb_master.sv
// Wishbone master that feeds buffered {x, d} samples to a memory-mapped
// LMS core and returns the filter output and error.
//   Clk, Rst            : clock, synchronous active-high reset
//   s_valid/s_ready     : input sample handshake, s_x / s_d sample data
//   mode_train          : requested LMS mode, written to MODE when it changes
//   m_valid/m_ready     : result handshake, m_y / m_err read back from the core
//   wb                  : Wishbone master port (see lms_wb_master_if)
//   timeout_o           : one-cycle pulse when a transaction is aborted
// Per sample: write X, write D, wait SETTLE cycles, read Y, read ERR, present.
// Each transaction holds cyc/stb until ack, then spends one idle "gap" cycle
// with the bus released before the sequencer moves on.
module lms_wb_master
    import lms_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_x,
    input  logic signed [SAMPLE_W-1:0] s_d,
    input  logic                       mode_train,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [SAMPLE_W-1:0] m_y,
    output logic signed [SAMPLE_W-1:0] m_err,
    lms_wb_master_if.master            wb,
    output logic                       timeout_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    lms_state_t state_reg, state_next;

    logic                  gap_reg;
    logic [TW-1:0]         timer_reg;
    logic [3:0]            settle_cnt_reg;
    logic                  last_mode_reg;
    logic                  mode_wr_reg;
    logic [SAMPLE_W-1:0]   m_y_reg;
    logic [SAMPLE_W-1:0]   m_err_reg;
    logic                  timeout_reg;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [2*SAMPLE_W-1:0] fifo_head;

    logic bus_active;
    logic bus_ack;
    logic bus_abort;
    logic settle_done;

    // A transaction is outstanding in the first phase of every bus state;
    // acks seen at any other time are ignored.
    assign bus_active  = is_bus_state(state_reg) && !gap_reg;
    assign bus_ack     = bus_active && wb.wb_ack_i;
    assign bus_abort   = bus_active && !wb.wb_ack_i && (timer_reg == TW'(TIMEOUT - 1));
    assign settle_done = (SETTLE == 0) || (settle_cnt_reg == 4'(SETTLE - 1));

    // The head sample leaves the buffer once D is written, or when a
    // transaction for it aborts before that point.
    assign fifo_push = s_valid && !fifo_full;
    assign fifo_pop  = ((state_reg == ST_WR_D) && bus_ack) ||
                       (bus_abort && ((state_reg == ST_WR_X) || (state_reg == ST_WR_D)));

    sync_fifo #(
        .WIDTH (2 * SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .push    (fifo_push),
        .wr_data ({s_x, s_d}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Mode changes are only considered in IDLE, so a MODE
    // write can never land inside one sample's X..ERR sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mode_train != last_mode_reg) begin
                    state_next = ST_WR_MODE;
                end else if (!fifo_empty) begin
                    state_next = ST_WR_X;
                end
            end
            ST_WR_MODE: if (bus_abort || gap_reg) state_next = ST_IDLE;
            ST_WR_X:    if (bus_abort) state_next = ST_IDLE; else if (gap_reg) state_next = ST_WR_D;
            ST_WR_D:    if (bus_abort) state_next = ST_IDLE; else if (gap_reg) state_next = ST_SETTLE;
            ST_SETTLE:  if (settle_done) state_next = ST_RD_Y;
            ST_RD_Y:    if (bus_abort) state_next = ST_IDLE; else if (gap_reg) state_next = ST_RD_E;
            ST_RD_E:    if (bus_abort) state_next = ST_IDLE; else if (gap_reg) state_next = ST_OUT;
            ST_OUT:     if (m_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output logic: bus fields are only non-zero while a transaction is out.
    always_comb begin
        wb.wb_cyc_o = bus_active;
        wb.wb_stb_o = bus_active;
        wb.wb_we_o  = 1'b0;
        wb.wb_adr_o = '0;
        wb.wb_dat_o = '0;
        if (bus_active) begin
            case (state_reg)
                ST_WR_MODE: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = ADR_MODE;
                    wb.wb_dat_o = {{(SAMPLE_W-1){1'b0}}, mode_wr_reg};
                end
                ST_WR_X: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = ADR_X;
                    wb.wb_dat_o = fifo_head[2*SAMPLE_W-1:SAMPLE_W];
                end
                ST_WR_D: begin
                    wb.wb_we_o  = 1'b1;
                    wb.wb_adr_o = ADR_D;
                    wb.wb_dat_o = fifo_head[SAMPLE_W-1:0];
                end
                ST_RD_Y: wb.wb_adr_o = ADR_Y;
                ST_RD_E: wb.wb_adr_o = ADR_ERR;
                default: ;
            endcase
        end
        m_valid = (state_reg == ST_OUT);
    end

    // Datapath and per-transaction bookkeeping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            gap_reg        <= 1'b0;
            timer_reg      <= '0;
            settle_cnt_reg <= '0;
            last_mode_reg  <= 1'b0;
            mode_wr_reg    <= 1'b0;
            m_y_reg        <= '0;
            m_err_reg      <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            // The gap lasts exactly the cycle after ack; an abort leaves it clear.
            gap_reg     <= bus_ack;
            timeout_reg <= bus_abort;
            timer_reg   <= (bus_active && !wb.wb_ack_i && !bus_abort) ? timer_reg + TW'(1) : '0;
            settle_cnt_reg <= ((state_reg == ST_SETTLE) && !settle_done) ?
                              settle_cnt_reg + 4'd1 : 4'd0;
            // Freeze the mode value for the whole MODE write so it stays stable.
            if ((state_reg == ST_IDLE) && (state_next == ST_WR_MODE)) begin
                mode_wr_reg <= mode_train;
            end
            if ((state_reg == ST_WR_MODE) && bus_ack) begin
                last_mode_reg <= mode_wr_reg;
            end
            if ((state_reg == ST_RD_Y) && bus_ack) begin
                m_y_reg <= wb.wb_dat_i;
            end
            if ((state_reg == ST_RD_E) && bus_ack) begin
                m_err_reg <= wb.wb_dat_i;
            end
        end
    end

    assign s_ready   = !fifo_full;
    assign m_y       = m_y_reg;
    assign m_err     = m_err_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_lms_wb_master.sv
// Self-checking bench for lms_wb_master. The bench acts as the Wishbone
// slave (LMS core register model with programmable ack latency / withheld
// acks / stray acks) and predicts bus traffic and results from the pushed
// samples. One line is printed per completed result handshake.
module tb_lms_wb_master;
    import lms_pkg::*;

    localparam int DEPTH   = 4;
    localparam int SET_CYC = 2;
    localparam int TMO     = 16;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [15:0] dat;
    } txn_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_x = '0;
    logic [15:0] s_d = '0;
    logic        mode_train = 1'b0;
    logic        m_ready = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [15:0] m_y;
    logic [15:0] m_err;
    logic        timeout_o;

    lms_wb_master_if bus();

    lms_wb_master #(.FIFO_DEPTH(DEPTH), .SETTLE(SET_CYC), .TIMEOUT(TMO)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_x        (s_x),
        .s_d        (s_d),
        .mode_train (mode_train),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_y        (m_y),
        .m_err      (m_err),
        .wb         (bus),
        .timeout_o  (timeout_o)
    );

    always #5 Clk = ~Clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // ---------------- slave model ----------------
    int          ack_delay  = 0;
    bit          withhold_y = 1'b0;
    bit          spurious   = 1'b0;
    bit          fixed_en   = 1'b0;
    logic [15:0] fixed_y    = '0;
    logic [15:0] fixed_e    = '0;
    logic [15:0] sx_reg     = '0;
    logic [15:0] sd_reg     = '0;
    logic        smode_reg  = 1'b0;
    int          wait_cnt   = 0;

    function automatic logic [15:0] ref_y(input logic [15:0] x);
        return (x ^ 16'hA5A5) + 16'd7;
    endfunction

    always_comb begin
        bus.wb_ack_i = 1'b0;
        if (bus.wb_stb_o) begin
            if (!(withhold_y && !bus.wb_we_o && bus.wb_adr_o == ADR_Y) && wait_cnt >= ack_delay)
                bus.wb_ack_i = 1'b1;
        end else begin
            bus.wb_ack_i = spurious;
        end
        if (bus.wb_adr_o == ADR_Y)
            bus.wb_dat_i = fixed_en ? fixed_y : ref_y(sx_reg);
        else if (bus.wb_adr_o == ADR_ERR)
            bus.wb_dat_i = fixed_en ? fixed_e : sd_reg - ref_y(sx_reg);
        else
            bus.wb_dat_i = 16'hDEAD;
    end

    always @(posedge Clk) begin
        if (bus.wb_stb_o && !bus.wb_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o) begin
            if (bus.wb_adr_o == ADR_X) sx_reg <= bus.wb_dat_o;
            if (bus.wb_adr_o == ADR_D) sd_reg <= bus.wb_dat_o;
            if (bus.wb_adr_o == ADR_MODE) smode_reg <= bus.wb_dat_o[0];
        end
    end

    // ---------------- monitor (mid-cycle sampling) ----------------
    txn_t        log_q[$];
    logic [31:0] out_q[$];
    int          out_time[$];
    int          cyc_n = 0, proto_err = 0, to_cnt = 0, abort_len = 0, cur_len = 0;
    logic        p_stb = 0, p_ack = 0, p_we = 0, p_to = 0, p_mv = 0, p_mr = 0;
    logic [31:0] p_adr = '0;
    logic [15:0] p_dat = '0, p_y = '0, p_e = '0;

    always @(negedge Clk) begin : mon
        int e;
        e = 0;
        if (bus.wb_cyc_o !== bus.wb_stb_o) e = e + 1;
        if (p_stb && !p_ack && bus.wb_stb_o &&
            (bus.wb_we_o !== p_we || bus.wb_adr_o !== p_adr || bus.wb_dat_o !== p_dat)) e = e + 1;
        if (p_stb && p_ack && bus.wb_stb_o) e = e + 1;
        if (timeout_o && p_to) e = e + 1;
        if (p_mv && !p_mr && (!m_valid || m_y !== p_y || m_err !== p_e)) e = e + 1;
        proto_err <= proto_err + e;
        cyc_n <= cyc_n + 1;
        if (bus.wb_stb_o) begin
            if (bus.wb_ack_i) begin
                log_q.push_back({bus.wb_we_o, bus.wb_adr_o, bus.wb_we_o ? bus.wb_dat_o : bus.wb_dat_i});
                cur_len <= 0;
            end else begin
                cur_len <= cur_len + 1;
            end
        end else begin
            if (p_stb && !p_ack) abort_len <= cur_len;
            cur_len <= 0;
        end
        if (timeout_o) to_cnt <= to_cnt + 1;
        if (m_valid && m_ready) begin
            out_q.push_back({m_y, m_err});
            out_time.push_back(cyc_n);
            $display("result y=%h err=%h at cycle %0d", m_y, m_err, cyc_n);
        end
        p_stb <= bus.wb_stb_o; p_ack <= bus.wb_ack_i; p_we <= bus.wb_we_o;
        p_adr <= bus.wb_adr_o; p_dat <= bus.wb_dat_o; p_to <= timeout_o;
        p_mv <= m_valid; p_mr <= m_ready; p_y <= m_y; p_e <= m_err;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_q[$];
    txn_t        exp_log[$];
    bit          rnd_mode = 1'b0;

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rnd_mode) begin
            spurious = ($urandom_range(0, 2) == 0);
            m_ready  = $urandom_range(0, 1);
        end
    endtask

    task automatic clear_all();
        log_q.delete(); out_q.delete(); out_time.delete();
        exp_q.delete(); exp_log.delete();
    endtask

    // A sample accepted by the buffer is expected to yield X/D writes,
    // Y/ERR reads and one result, in arrival order.
    task automatic push(input logic [15:0] x, input logic [15:0] d);
        logic [15:0] y, e;
        s_valid = 1'b1; s_x = x; s_d = d;
        for (int n = 0; n < 300; n++) begin
            if (s_ready) begin
                tick();
                s_valid = 1'b0;
                y = fixed_en ? fixed_y : ref_y(x);
                e = fixed_en ? fixed_e : d - ref_y(x);
                exp_q.push_back({y, e});
                exp_log.push_back({1'b1, ADR_X, x});
                exp_log.push_back({1'b1, ADR_D, d});
                exp_log.push_back({1'b0, ADR_Y, y});
                exp_log.push_back({1'b0, ADR_ERR, e});
                return;
            end
            tick();
        end
        s_valid = 1'b0;
        chk_cnt++;
        $display("FAIL push_accept got s_ready=0 for 300 cycles want accept");
    endtask

    task automatic wait_outputs(input int n, input int budget);
        for (int i = 0; i < budget && out_q.size() < n; i++) tick();
        chk_cnt++;
        if (out_q.size() != n) $display("FAIL out_count got %0d want %0d", out_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic compare_queues(input string tag);
        chk_cnt++;
        if (log_q.size() != exp_log.size())
            $display("FAIL %s_log_len got %0d want %0d", tag, log_q.size(), exp_log.size());
        else pass_cnt++;
        for (int i = 0; i < log_q.size() && i < exp_log.size(); i++) begin
            chk_cnt++;
            if (log_q[i] !== exp_log[i]) $display("FAIL %s_log%0d got %h want %h", tag, i, log_q[i], exp_log[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (out_q.size() != exp_q.size())
            $display("FAIL %s_out_len got %0d want %0d", tag, out_q.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            chk_cnt++;
            if (out_q[i] !== exp_q[i]) $display("FAIL %s_out%0d got %h want %h", tag, i, out_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst = 1'b1; mode_train = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        Rst = 1'b0;
        chk_cnt++; if (bus.wb_cyc_o !== 1'b0) $display("FAIL rst_cyc got %b want 0", bus.wb_cyc_o); else pass_cnt++;
        chk_cnt++; if (bus.wb_stb_o !== 1'b0) $display("FAIL rst_stb got %b want 0", bus.wb_stb_o); else pass_cnt++;
        chk_cnt++; if (bus.wb_we_o !== 1'b0) $display("FAIL rst_we got %b want 0", bus.wb_we_o); else pass_cnt++;
        chk_cnt++; if (bus.wb_adr_o !== 32'h0) $display("FAIL rst_adr got %h want 0", bus.wb_adr_o); else pass_cnt++;
        chk_cnt++; if (bus.wb_dat_o !== 16'h0) $display("FAIL rst_dat got %h want 0", bus.wb_dat_o); else pass_cnt++;
        chk_cnt++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b want 0", m_valid); else pass_cnt++;
        chk_cnt++; if (m_y !== 16'h0 || m_err !== 16'h0) $display("FAIL rst_m_data got %h/%h want 0/0", m_y, m_err); else pass_cnt++;
        chk_cnt++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout got %b want 0", timeout_o); else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready got %b want 1", s_ready); else pass_cnt++;
        clear_all();
        repeat (6) tick();
        chk_cnt++; if (log_q.size() != 0) $display("FAIL rst_idle_bus got %0d txns want 0", log_q.size()); else pass_cnt++;
    endtask

    task automatic test_mode_write();
        clear_all();
        mode_train = 1'b1;
        repeat (10) tick();
        chk_cnt++;
        if (log_q.size() != 1) $display("FAIL mode_txn_count got %0d want 1", log_q.size());
        else pass_cnt++;
        if (log_q.size() > 0) begin
            chk_cnt++;
            if (log_q[0] !== {1'b1, ADR_MODE, 16'h0001}) $display("FAIL mode_txn got %h want %h", log_q[0], {1'b1, ADR_MODE, 16'h0001});
            else pass_cnt++;
        end
    endtask

    task automatic test_single_sample();
        clear_all();
        fixed_en = 1'b1; fixed_y = 16'h0050; fixed_e = 16'h01B0; m_ready = 1'b1; ack_delay = 0;
        push(16'h0100, 16'h0200);
        wait_outputs(1, 100);
        compare_queues("single");
        fixed_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_all();
        m_ready = 1'b0; ack_delay = 0;
        for (int i = 0; i < 5; i++) begin
            push(16'($urandom), 16'($urandom));
            if (i == 3) begin
                chk_cnt++;
                if (s_ready !== 1'b0) $display("FAIL b2b_full got s_ready=%b want 0", s_ready); else pass_cnt++;
            end
        end
        repeat (30) tick();
        chk_cnt++;
        if (out_q.size() != 0 || m_valid !== 1'b1) $display("FAIL b2b_hold got out=%0d m_valid=%b want 0/1", out_q.size(), m_valid);
        else pass_cnt++;
        m_ready = 1'b1;
        wait_outputs(5, 400);
        compare_queues("b2b");
        for (int i = 1; i < out_time.size(); i++) begin
            chk_cnt++;
            if (out_time[i] - out_time[i-1] != 8 + SET_CYC + 2)
                $display("FAIL b2b_rate%0d got %0d want %0d", i, out_time[i] - out_time[i-1], 8 + SET_CYC + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int base;
        clear_all();
        base = proto_err;
        rnd_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            ack_delay = $urandom_range(0, 3);
            push(16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        rnd_mode = 1'b0; spurious = 1'b0; m_ready = 1'b1;
        wait_outputs(25, 2000);
        compare_queues("rand");
        chk_cnt++;
        if (proto_err != base) $display("FAIL rand_protocol got %0d violations want 0", proto_err - base);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int t0;
        clear_all();
        ack_delay = 0; m_ready = 1'b1; withhold_y = 1'b1;
        t0 = to_cnt;
        push(16'h1234, 16'h4321);
        // The withheld sample is discarded: only its two writes complete.
        void'(exp_q.pop_back());
        void'(exp_log.pop_back());
        void'(exp_log.pop_back());
        for (int i = 0; i < 200 && to_cnt == t0; i++) tick();
        withhold_y = 1'b0;
        chk_cnt++; if (to_cnt != t0 + 1) $display("FAIL tmo_pulse got %0d pulses want 1", to_cnt - t0); else pass_cnt++;
        chk_cnt++; if (abort_len != TMO) $display("FAIL tmo_len got %0d want %0d", abort_len, TMO); else pass_cnt++;
        repeat (5) tick();
        chk_cnt++; if (out_q.size() != 0) $display("FAIL tmo_no_result got %0d want 0", out_q.size()); else pass_cnt++;
        push(16'h0A0B, 16'h0C0D);
        wait_outputs(1, 100);
        compare_queues("tmo");
        chk_cnt++; if (to_cnt != t0 + 1) $display("FAIL tmo_after got %0d pulses want 1", to_cnt - t0); else pass_cnt++;
    endtask

    task automatic test_mode_toggle();
        bit seen;
        clear_all();
        m_ready = 1'b0; ack_delay = 0;
        push(16'h2222, 16'h3333);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.wb_stb_o && bus.wb_adr_o == ADR_D) seen = 1'b1;
            else tick();
        end
        chk_cnt++; if (!seen) $display("FAIL toggle_wr_d got no D write want one"); else pass_cnt++;
        mode_train = 1'b0;
        for (int i = 0; i < 50 && !m_valid; i++) tick();
        repeat (5) tick();
        chk_cnt++;
        if (log_q.size() != 4) $display("FAIL toggle_no_early_mode got %0d txns want 4", log_q.size()); else pass_cnt++;
        m_ready = 1'b1;
        exp_log.push_back({1'b1, ADR_MODE, 16'h0000});
        repeat (15) tick();
        compare_queues("toggle");
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_all();
        mode_train = 1'b0; m_ready = 1'b1; ack_delay = 8;
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clk);
            if (bus.wb_stb_o && bus.wb_we_o && bus.wb_adr_o == ADR_X) seen = 1'b1;
        end
        chk_cnt++; if (!seen) $display("FAIL rmid_wr_x got no X strobe want one"); else pass_cnt++;
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk_cnt++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) $display("FAIL rmid_cyc_stb got %b%b want 00", bus.wb_cyc_o, bus.wb_stb_o); else pass_cnt++;
        chk_cnt++; if (bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 16'h0 || bus.wb_we_o !== 1'b0) $display("FAIL rmid_bus got %h/%h/%b want 0", bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o); else pass_cnt++;
        chk_cnt++; if (m_valid !== 1'b0 || m_y !== 16'h0 || m_err !== 16'h0 || timeout_o !== 1'b0) $display("FAIL rmid_out got %b %h %h %b want 0", m_valid, m_y, m_err, timeout_o); else pass_cnt++;
        chk_cnt++; if (s_ready !== 1'b1) $display("FAIL rmid_s_ready got %b want 1", s_ready); else pass_cnt++;
        Rst = 1'b0; ack_delay = 0;
        log_q.delete();
        repeat (30) tick();
        chk_cnt++; if (log_q.size() != 0 || out_q.size() != 0) $display("FAIL rmid_fifo_empty got %0d txns %0d results want 0", log_q.size(), out_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mode_write();
        test_single_sample();
        test_back_to_back();
        test_random();
        test_timeout();
        test_mode_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/lms_wb_master.md
LMS_WB_MASTER -- requirements
Module: lms_wb_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input sample buffer depth (power of two, >=2).
REQ-002 Parameter SETTLE, default 2, idle cycles between the d_in write and the y_out read (0..15).
REQ-003 Parameter TIMEOUT, default 16, cycles to wait for wb_ack_i before aborting a transaction.
REQ-004 Clk  input  1  sole clock; all logic on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  input sample valid.
REQ-007 s_ready  output  1  buffer can accept a sample.
REQ-008 s_x  input  16  signed reference sample x.
REQ-009 s_d  input  16  signed desired sample d.
REQ-010 mode_train  input  1  requested LMS mode (1 = train).
REQ-011 m_valid  output  1  result valid.
REQ-012 m_ready  input  1  result consumer ready.
REQ-013 m_y  output  16  filter output read back.
REQ-014 m_err  output  16  error read back.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master strobes.
REQ-016 wb_adr_o  output  32  byte address.
REQ-017 wb_dat_o  output  16  write data.
REQ-018 wb_dat_i  input  16  read data.
REQ-019 wb_ack_i  input  1  slave acknowledge.
REQ-020 timeout_o  output  1  one-cycle pulse on transaction abort.

Function
REQ-021 Address map: X=0x00, D=0x04, MODE=0x08, Y=0x0C, ERR=0x10; all other bits zero.
REQ-022 Input buffer is a FIFO_DEPTH-entry FIFO of {s_x,s_d}; push when s_valid && s_ready; s_ready = !full; simultaneous push and pop when full is refused (push only when !full).
REQ-023 FSM states: IDLE, WR_MODE, WR_X, WR_D, SETTLE, RD_Y, RD_E, OUT.
REQ-024 IDLE: if mode_train differs from the last written mode -> WR_MODE; else if FIFO non-empty -> WR_X; mode check has priority.
REQ-025 WR_MODE writes {15'b0,mode_train} to MODE, then -> IDLE; the written value is recorded as the last mode.
REQ-026 WR_X writes head x; WR_D writes head d and pops the FIFO on ack; then -> SETTLE.
REQ-027 SETTLE counts SETTLE cycles (0 = pass through in one cycle) -> RD_Y; RD_Y captures wb_dat_i into m_y on ack -> RD_E; RD_E captures m_err on ack -> OUT.
REQ-028 OUT holds m_valid=1 with m_y/m_err stable until m_ready; on the handshake cycle -> IDLE.
REQ-029 Bus cycle: cyc=stb=1 with adr/we/dat stable from the state's first cycle until the cycle wb_ack_i=1 is sampled; cyc/stb drop in the cycle after ack; at least one idle bus cycle between transactions.
REQ-030 Ack sampled while no transaction is outstanding is ignored.
REQ-031 Per transaction a counter runs; if TIMEOUT cycles pass without ack: drop cyc/stb, pulse timeout_o, discard the current sample (pop if not yet popped), -> IDLE; no m_valid for that sample.
REQ-032 A write to MODE never occurs between WR_X and RD_E of one sample; a mode change takes effect before the next sample.
REQ-033 Throughput: with a single-cycle-ack slave and m_ready=1, one sample per (4 transactions x 2 + SETTLE + 2) cycles maximum.

Reset
REQ-034 On Rst: FIFO empty, FSM IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, m_valid=0, m_y=m_err=0, timeout_o=0, s_ready=1 from the cycle after reset.
REQ-035 Last-mode register resets to 0 so that mode_train=1 forces a MODE write first.
REQ-036 Rst asserted mid-transaction drops cyc/stb in the next cycle; the in-flight sample is lost.

Structure
REQ-037 Shared package lms_pkg holds register address constants, FSM state enum and sample width (16).
REQ-038 One sub-module sync_fifo (parameterised width/depth, push/pop/full/empty) implements the input buffer.

Verification
REQ-039 Reset then mode_train=1 -> one write adr 0x08 dat 0x0001 before any sample traffic.
REQ-040 Push x=0x0100, d=0x0200 with single-cycle-ack slave returning y=0x0050, err=0x01B0 -> writes 0x00/0x0100, 0x04/0x0200, reads 0x0C, 0x10, m_valid with m_y=0x0050, m_err=0x01B0.
REQ-041 Push 5 samples back-to-back, m_ready=0 -> s_ready low after 4 accepted (FIFO_DEPTH=4 less one in flight at most), no sample lost or reordered after m_ready=1.
REQ-042 Slave withholds ack on RD_Y -> timeout_o pulse after 16 cycles, no m_valid, next sample proceeds normally.
REQ-043 Toggle mode_train during a sample's WR_D -> MODE write issued only after that sample's OUT handshake.
REQ-044 Assert Rst while stb high on WR_X -> cyc/stb low next cycle, all outputs at reset values, FIFO empty.
